gpio_bidir_filt: RTL and testbench

Parametrised successor to the GPIO bidirectional pad block. It registers the per-pin drive controls and supports push-pull or open-drain drive per pin. Each input passes through a configurable synchroniser and a per-pin glitch filter. Sticky rise/fall edge capture per pin feeds a single maskable interrupt. The block sits between the hostmot2-style register file and the FPGA GPIO header pins.

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_pin_filt.sv | 58 +++++
 rtl/gpio_bidir_filt.sv | 119 +++++++++++
 tb/tb_gpio_bidir_filt.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO bidirectional pad block.
//   IO_WIDTH_DEF / SYNC_STAGES_DEF / FILT_WIDTH_DEF : default parameter values
//   filt_cnt_t  : filter length / counter type at the default width
//   INIT_CYCLES : post-reset cycles with forced bypass at the default depth
//   init_cycles : same quantity for an arbitrary synchroniser depth
package gpio_pkg;

  localparam int unsigned IO_WIDTH_DEF    = 36;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILT_WIDTH_DEF  = 4;

  typedef logic [FILT_WIDTH_DEF-1:0] filt_cnt_t;

  localparam int unsigned INIT_CYCLES = SYNC_STAGES_DEF + 1;

  // Synchroniser depth plus the filt register.
  function automatic int unsigned init_cycles(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/gpio_pin_filt.sv
// One pin's input path: synchroniser chain, glitch-filter counter and the
// filtered-state register.
//   clk, reset : clock and synchronous active-high reset
//   pin        : raw pad value
//   bypass     : 1 = copy synchroniser output straight to filt
//   filt_len   : cycles a new level must persist before it is accepted
//   filt       : filtered pin state (registered)
module gpio_pin_filt
  import gpio_pkg::*;
#(
  parameter int unsigned SyncStages = SYNC_STAGES_DEF,
  parameter int unsigned FiltWidth  = FILT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pin,
  input  logic                 bypass,
  input  logic [FiltWidth-1:0] filt_len,
  output logic                 filt
);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic [FiltWidth-1:0]  cnt;

  assign sync = sync_q[SyncStages-1];

  // Metastability chain; bit 0 samples the pad.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin};
    end
  end

  // cnt tracks consecutive cycles where sync disagrees with filt; the level
  // is accepted on the filt_len-th disagreeing cycle. filt_len is used
  // unregistered, so a shorter length can leave cnt above the limit and the
  // >= compare then accepts on the next disagreeing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (bypass || (filt_len == '0)) begin
      filt <= sync;
      cnt  <= '0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt >= (filt_len - FiltWidth'(1))) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + FiltWidth'(1);
    end
  end

endmodule

// File: rtl/gpio_bidir_filt.sv
// GPIO bidirectional pad block: registered push-pull/open-drain drive,
// synchronised and glitch-filtered inputs, sticky edge flags, maskable irq.
//   clk, reset            : clock and synchronous active-high reset
//   oe, od, out_data      : per-pin drive controls (registered internally)
//   filt_en, filt_len     : per-pin filter enable, shared filter length
//   rise_mask, fall_mask  : edge interrupt enables
//   clr_rise, clr_fall    : one-cycle clear pulses for the sticky flags
//   gpioport              : pads
//   read_data             : filtered pin state
//   rise_pend, fall_pend  : sticky edge flags
//   irq                   : OR of masked flags (combinational from registers)
module gpio_bidir_filt
  import gpio_pkg::*;
#(
  parameter int unsigned IOWidth    = IO_WIDTH_DEF,
  parameter int unsigned SyncStages = SYNC_STAGES_DEF,
  parameter int unsigned FiltWidth  = FILT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IOWidth-1:0]   oe,
  input  logic [IOWidth-1:0]   od,
  input  logic [IOWidth-1:0]   out_data,
  input  logic [IOWidth-1:0]   filt_en,
  input  logic [FiltWidth-1:0] filt_len,
  input  logic [IOWidth-1:0]   rise_mask,
  input  logic [IOWidth-1:0]   fall_mask,
  input  logic [IOWidth-1:0]   clr_rise,
  input  logic [IOWidth-1:0]   clr_fall,
  inout  wire  [IOWidth-1:0]   gpioport,
  output logic [IOWidth-1:0]   read_data,
  output logic [IOWidth-1:0]   rise_pend,
  output logic [IOWidth-1:0]   fall_pend,
  output logic                 irq
);

  localparam int unsigned InitCycles = init_cycles(SyncStages);
  localparam int unsigned InitW      = $clog2(InitCycles + 2);
  localparam int unsigned ArmCount   = InitCycles + 1;

  logic [IOWidth-1:0] oe_reg;
  logic [IOWidth-1:0] od_reg;
  logic [IOWidth-1:0] out_reg;
  logic [IOWidth-1:0] pad_en;
  logic [IOWidth-1:0] pad_val;
  logic [IOWidth-1:0] prev;
  logic [IOWidth-1:0] rise_det;
  logic [IOWidth-1:0] fall_det;
  logic [InitW-1:0]   init_cnt;
  logic               init_bypass;
  logic               capture_en;

  // Drive controls are registered so pads change one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      oe_reg  <= '0;
      od_reg  <= '0;
      out_reg <= '0;
    end else begin
      oe_reg  <= oe;
      od_reg  <= od;
      out_reg <= out_data;
    end
  end

  // Open-drain pins only ever pull low; a 1 releases the pad.
  assign pad_en  = oe_reg & (~od_reg | ~out_reg);
  assign pad_val = out_reg & ~od_reg;

  for (genvar i = 0; i < IOWidth; i++) begin : g_pin
    assign gpioport[i] = pad_en[i] ? pad_val[i] : 1'bz;

    gpio_pin_filt #(
      .SyncStages (SyncStages),
      .FiltWidth  (FiltWidth)
    ) u_filt (
      .clk      (clk),
      .reset    (reset),
      .pin      (gpioport[i]),
      .bypass   (init_bypass | ~filt_en[i]),
      .filt_len (filt_len),
      .filt     (read_data[i])
    );
  end

  // Counts edges since reset release and saturates once capture is armed.
  // Edges 1..InitCycles force bypass so filt follows the pads straight away;
  // the next edge loads prev with that settled value, and capture starts on
  // the edge after, so the reset value of 0 never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (init_cnt != InitW'(ArmCount)) begin
      init_cnt <= init_cnt + InitW'(1);
    end
  end

  assign init_bypass = (init_cnt < InitW'(InitCycles));
  assign capture_en  = (init_cnt == InitW'(ArmCount));

  assign rise_det = read_data & ~prev;
  assign fall_det = ~read_data & prev;

  // Sticky flags; a detected edge wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
    end else begin
      prev      <= read_data;
      rise_pend <= (rise_pend & ~clr_rise) | (capture_en ? rise_det : '0);
      fall_pend <= (fall_pend & ~clr_fall) | (capture_en ? fall_det : '0);
    end
  end

  assign irq = |((rise_pend & rise_mask) | (fall_pend & fall_mask));

endmodule

// File: tb/tb_gpio_bidir_filt.sv
// Self-checking bench for gpio_bidir_filt: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural pad/filter/flag model.
module tb_gpio_bidir_filt;

  localparam int unsigned IOW  = 36;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FW   = 4;
  localparam int          INIT = SYNC + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [IOW-1:0] oe, od, out_data, filt_en, rise_mask, fall_mask, clr_rise, clr_fall;
  logic [FW-1:0]  filt_len;
  wire  [IOW-1:0] gpioport;
  logic [IOW-1:0] read_data, rise_pend, fall_pend;
  logic           irq;

  // External world: drives ext_val on every pad the model says is released.
  logic [IOW-1:0] ext_val;
  logic [IOW-1:0] ext_drive;

  for (genvar i = 0; i < IOW; i++) begin : g_ext
    assign gpioport[i] = ext_drive[i] ? ext_val[i] : 1'bz;
  end

  gpio_bidir_filt #(
    .IOWidth    (IOW),
    .SyncStages (SYNC),
    .FiltWidth  (FW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .oe        (oe),
    .od        (od),
    .out_data  (out_data),
    .filt_en   (filt_en),
    .filt_len  (filt_len),
    .rise_mask (rise_mask),
    .fall_mask (fall_mask),
    .clr_rise  (clr_rise),
    .clr_fall  (clr_fall),
    .gpioport  (gpioport),
    .read_data (read_data),
    .rise_pend (rise_pend),
    .fall_pend (fall_pend),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [IOW-1:0] act, input logic [IOW-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [IOW-1:0] rnd36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[IOW-1:0];
  endfunction

  // ---------------- behavioural model ----------------
  logic [IOW-1:0] m_oe, m_od, m_out;     // requested drive as seen by the pads
  logic [IOW-1:0] m_filt, m_prev, m_rp, m_fp;
  logic [IOW-1:0] drv_en, drv_val;
  logic [IOW-1:0] hist [SYNC];           // hist[k] = pad value k+1 edges ago
  int             streak [IOW];          // consecutive disagreeing cycles
  int             since;                 // edges since reset released

  function automatic logic [IOW-1:0] exp_pins();
    return (drv_en & drv_val) | (~drv_en & ext_val);
  endfunction

  task automatic model_edge();
    logic [IOW-1:0] pad, sync_v, rise_v, fall_v;
    bit armed;
    pad = exp_pins();
    if (reset) begin
      m_oe = '0; m_od = '0; m_out = '0;
      m_filt = '0; m_prev = '0; m_rp = '0; m_fp = '0;
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
      for (int i = 0; i < IOW; i++) streak[i] = 0;
      since = 0;
    end else begin
      since++;
      sync_v = hist[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pad;
      armed  = (since >= INIT + 2);
      rise_v = m_filt & ~m_prev;
      fall_v = ~m_filt & m_prev;
      m_rp   = (m_rp & ~clr_rise) | (armed ? rise_v : '0);
      m_fp   = (m_fp & ~clr_fall) | (armed ? fall_v : '0);
      m_prev = m_filt;
      for (int i = 0; i < IOW; i++) begin
        if (since <= INIT || !filt_en[i] || filt_len == 0) begin
          m_filt[i] = sync_v[i];
          streak[i] = 0;
        end else if (sync_v[i] == m_filt[i]) begin
          streak[i] = 0;
        end else begin
          streak[i]++;
          if (streak[i] >= int'(filt_len)) begin
            m_filt[i] = sync_v[i];
            streak[i] = 0;
          end
        end
      end
      m_oe = oe; m_od = od; m_out = out_data;
    end
    // Push-pull drives the data; open-drain only ever drives a 0.
    for (int i = 0; i < IOW; i++) begin
      drv_en[i]  = m_oe[i] && !(m_od[i] && m_out[i]);
      drv_val[i] = m_od[i] ? 1'b0 : m_out[i];
    end
  endtask

  // Model update on each rising edge, comparison on each falling edge.
  initial begin
    drv_en = '0; drv_val = '0; ext_drive = '1;
    m_oe = '0; m_od = '0; m_out = '0; m_filt = '0; m_prev = '0; m_rp = '0; m_fp = '0;
    since = 0;
    for (int k = 0; k < SYNC; k++) hist[k] = '0;
    for (int i = 0; i < IOW; i++) streak[i] = 0;
    forever begin
      @(posedge clk);
      model_edge();
      #1 ext_drive = ~drv_en;
      @(negedge clk);
      check("read_data", read_data, m_filt);
      check("rise_pend", rise_pend, m_rp);
      check("fall_pend", fall_pend, m_fp);
      check("irq", IOW'(irq), IOW'(|((m_rp & rise_mask) | (m_fp & fall_mask))));
      check("pins", gpioport, exp_pins());
    end
  end

  // Returns just after the n-th falling edge (after that edge's compare).
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1;
    oe = '0; od = '0; out_data = '0; filt_en = '0; filt_len = '0;
    rise_mask = '0; fall_mask = '0; clr_rise = '0; clr_fall = '0;
    ext_val = 36'h0_FFFF_FFFF;

    // Reset with pads pulled to 0x0_FFFF_FFFF; nothing driven by the block.
    tick(3);
    check("rst_pins", gpioport, 36'h0_FFFF_FFFF);
    check("rst_read", read_data, '0);
    reset = 1'b0;
    rise_mask = '1;
    tick(INIT);
    check("init_read", read_data, 36'h0_FFFF_FFFF);
    tick(4);
    check("init_rise", rise_pend, '0);
    check("init_irq", IOW'(irq), '0);

    // Push-pull output.
    oe = '1; od = '0; out_data = 36'hA_5A5A_5A5A;
    tick(1);
    check("pp_pins", gpioport, 36'hA_5A5A_5A5A);

    // Open-drain: 0 bits pulled low, 1 bits released to the pull-up.
    ext_val = '1; od = '1;
    tick(1);
    check("od_pins", gpioport, 36'hA_5A5A_5A5A);

    // Release everything, settle low, clear flags.
    oe = '0; od = '0; out_data = '0; ext_val = '0; rise_mask = '0;
    tick(8);
    clr_rise = '1; clr_fall = '1;
    tick(1);
    clr_rise = '0; clr_fall = '0;
    check("clr_all", rise_pend | fall_pend, '0);

    // Filter on pin 3, length 4: a 3-cycle pulse is rejected.
    filt_en = 36'h8; filt_len = 4'd4;
    tick(2);
    ext_val[3] = 1'b1;
    tick(3);
    ext_val[3] = 1'b0;
    tick(6);
    check("glitch_read", IOW'(read_data[3]), '0);
    check("glitch_rise", IOW'(rise_pend[3]), '0);
    // A 4-cycle pulse passes after SyncStages+4 edges.
    ext_val[3] = 1'b1;
    tick(SYNC + 3);
    check("filt_early", IOW'(read_data[3]), '0);
    tick(1);
    check("filt_read", IOW'(read_data[3]), 36'h1);
    check("filt_rise0", IOW'(rise_pend[3]), '0);
    tick(1);
    check("filt_rise1", IOW'(rise_pend[3]), 36'h1);
    ext_val[3] = 1'b0;
    tick(10);
    clr_rise = '1; clr_fall = '1;
    tick(1);
    clr_rise = '0; clr_fall = '0;

    // Interrupt and clear on pin 0 (bypass).
    filt_en = '0; rise_mask = 36'h1;
    tick(1);
    check("irq_idle", IOW'(irq), '0);
    ext_val[0] = 1'b1;
    tick(INIT);
    check("irq_read", IOW'(read_data[0]), 36'h1);
    check("irq_pre", IOW'(irq), '0);
    tick(1);
    check("irq_set", IOW'(irq), 36'h1);
    clr_rise[0] = 1'b1;
    tick(1);
    clr_rise[0] = 1'b0;
    check("irq_clr", IOW'(irq), '0);
    ext_val[0] = 1'b0;
    tick(6);
    ext_val[0] = 1'b1;
    tick(INIT);
    clr_rise[0] = 1'b1;
    tick(1);
    clr_rise[0] = 1'b0;
    check("set_wins", IOW'(rise_pend[0]), 36'h1);

    // Reset while pin 5's filter is mid-count.
    filt_en = 36'h20; filt_len = 4'd4;
    tick(3);
    ext_val[5] = 1'b1;
    tick(SYNC + 2);
    reset = 1'b1;
    tick(1);
    check("mrst_read", read_data, '0);
    check("mrst_flags", rise_pend | fall_pend, '0);
    check("mrst_irq", IOW'(irq), '0);
    tick(2);
    reset = 1'b0;
    tick(12);
    check("mrst_noedge", rise_pend | fall_pend, '0);
    check("mrst_pin5", IOW'(read_data[5]), 36'h1);

    // Randomized traffic.
    rise_mask = rnd36(); fall_mask = rnd36();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) oe = rnd36();
      if ($urandom_range(0, 15) == 0) od = rnd36();
      out_data = out_data ^ (rnd36() & rnd36() & rnd36());
      if ($urandom_range(0, 31) == 0) filt_en = rnd36();
      if ($urandom_range(0, 63) == 0)
        filt_len = ($urandom_range(0, 7) == 0) ? FW'($urandom_range(6, 15)) : FW'($urandom_range(0, 5));
      if ($urandom_range(0, 63) == 0) rise_mask = rnd36();
      if ($urandom_range(0, 63) == 0) fall_mask = rnd36();
      clr_rise = rnd36() & rnd36() & rnd36();
      clr_fall = rnd36() & rnd36() & rnd36();
      ext_val  = ext_val ^ (rnd36() & rnd36() & rnd36() & rnd36());
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
